// File: rtl/regbank_pkg.sv
// +--------------------------------------------------------------------------+
// | regbank_pkg                                                              |
// | Shared defaults and dump-engine state encoding for the bank read side.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

package regbank_pkg;

  localparam int c_mem_width = 32;
  localparam int c_mem_depth = 32;

  typedef enum logic [1:0] {
    DUMP_IDLE = 2'd0,
    DUMP_EMIT = 2'd1,
    DUMP_LAST = 2'd2
  } dump_state_e;

endpackage

`default_nettype wire

// File: rtl/regbank_read_sel.sv
// +--------------------------------------------------------------------------+
// | regbank_read_sel                                                         |
// | Combinational entry select with write-first bypass and hardwired x0.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module regbank_read_sel
  import regbank_pkg::*;
#(
  parameter int mem_width  = c_mem_width,
  parameter int mem_depth  = c_mem_depth,
  parameter int addr_width = $clog2(mem_depth),
  parameter bit zero_reg   = 1'b1
) (
  input  logic [mem_width*mem_depth-1:0] bank_q,
  input  logic                           we,
  input  logic [addr_width-1:0]          waddr,
  input  logic [mem_width-1:0]           wdata,
  input  logic [addr_width-1:0]          addr,
  output logic [mem_width-1:0]           rdata
);

  logic [mem_width-1:0] w_entries [mem_depth];

  for (genvar gi = 0; gi < mem_depth; gi++) begin : g_unpack
    assign w_entries[gi] = bank_q[gi*mem_width +: mem_width];
  end

  // Zero rule is applied last so a write to entry 0 can never leak through.
  always_comb begin
    rdata = w_entries[addr];
    if (we && (waddr == addr)) begin
      rdata = wdata;
    end
    if (zero_reg && (addr == '0)) begin
      rdata = '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regbank_read_port.sv
// +--------------------------------------------------------------------------+
// | regbank_read_port                                                        |
// | Registered rs1/rs2 operand reads plus a valid/ready debug dump engine.   |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module regbank_read_port
  import regbank_pkg::*;
#(
  parameter int mem_width  = c_mem_width,
  parameter int mem_depth  = c_mem_depth,
  parameter int addr_width = $clog2(mem_depth),
  parameter bit zero_reg   = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [mem_width*mem_depth-1:0] bank_q,
  input  logic                           we,
  input  logic [addr_width-1:0]          waddr,
  input  logic [mem_width-1:0]           wdata,
  input  logic                           stall,
  input  logic [addr_width-1:0]          rs1_addr,
  input  logic [addr_width-1:0]          rs2_addr,
  output logic [mem_width-1:0]           rs1_data,
  output logic [mem_width-1:0]           rs2_data,
  input  logic                           dump_start,
  input  logic                           dump_ready,
  output logic                           dump_valid,
  output logic [addr_width-1:0]          dump_index,
  output logic [mem_width-1:0]           dump_data,
  output logic                           dump_busy,
  output logic                           dump_done
);

  localparam logic [1:0] c_st_idle = 2'(DUMP_IDLE);
  localparam logic [1:0] c_st_emit = 2'(DUMP_EMIT);
  localparam logic [1:0] c_st_last = 2'(DUMP_LAST);

  localparam logic [addr_width-1:0] c_last_idx = addr_width'(mem_depth - 1);

  logic [1:0]            r_state;
  logic [mem_width-1:0]  r_rs1_data;
  logic [mem_width-1:0]  r_rs2_data;
  logic [mem_width-1:0]  r_dump_data;
  logic [addr_width-1:0] r_dump_index;
  logic                  r_dump_valid;
  logic                  r_dump_busy;
  logic                  r_dump_done;

  logic [mem_width-1:0]  w_rs1_sel;
  logic [mem_width-1:0]  w_rs2_sel;
  logic [mem_width-1:0]  w_dump_sel;
  logic [addr_width-1:0] w_next_idx;
  logic [addr_width-1:0] w_dump_addr;
  logic                  w_beat_accept;

  assign w_next_idx    = r_dump_index + addr_width'(1);
  assign w_dump_addr   = (r_state == c_st_idle) ? '0 : w_next_idx;
  assign w_beat_accept = r_dump_valid && dump_ready;

  regbank_read_sel #(
    .mem_width  (mem_width),
    .mem_depth  (mem_depth),
    .addr_width (addr_width),
    .zero_reg   (zero_reg)
  ) u_sel_rs1 (
    .bank_q (bank_q),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .addr   (rs1_addr),
    .rdata  (w_rs1_sel)
  );

  regbank_read_sel #(
    .mem_width  (mem_width),
    .mem_depth  (mem_depth),
    .addr_width (addr_width),
    .zero_reg   (zero_reg)
  ) u_sel_rs2 (
    .bank_q (bank_q),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .addr   (rs2_addr),
    .rdata  (w_rs2_sel)
  );

  regbank_read_sel #(
    .mem_width  (mem_width),
    .mem_depth  (mem_depth),
    .addr_width (addr_width),
    .zero_reg   (zero_reg)
  ) u_sel_dump (
    .bank_q (bank_q),
    .we     (we),
    .waddr  (waddr),
    .wdata  (wdata),
    .addr   (w_dump_addr),
    .rdata  (w_dump_sel)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rs1_data <= '0;
      r_rs2_data <= '0;
    end else if (!stall) begin
      r_rs1_data <= w_rs1_sel;
      r_rs2_data <= w_rs2_sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= c_st_idle;
      r_dump_data  <= '0;
      r_dump_index <= '0;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      r_dump_done <= 1'b0;
      case (r_state)
        c_st_idle: begin
          // A start coinciding with the done pulse is deliberately dropped.
          if (dump_start && !r_dump_done) begin
            r_dump_index <= '0;
            r_dump_data  <= w_dump_sel;
            r_dump_valid <= 1'b1;
            r_dump_busy  <= 1'b1;
            r_state      <= (mem_depth == 1) ? c_st_last : c_st_emit;
          end
        end
        c_st_emit: begin
          if (w_beat_accept) begin
            r_dump_index <= w_next_idx;
            r_dump_data  <= w_dump_sel;
            if (w_next_idx == c_last_idx) begin
              r_state <= c_st_last;
            end
          end
        end
        c_st_last: begin
          if (w_beat_accept) begin
            r_dump_valid <= 1'b0;
            r_dump_busy  <= 1'b0;
            r_dump_done  <= 1'b1;
            r_state      <= c_st_idle;
          end
        end
        default: begin
          r_state      <= c_st_idle;
          r_dump_valid <= 1'b0;
          r_dump_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign rs1_data   = r_rs1_data;
  assign rs2_data   = r_rs2_data;
  assign dump_valid = r_dump_valid;
  assign dump_index = r_dump_index;
  assign dump_data  = r_dump_data;
  assign dump_busy  = r_dump_busy;
  assign dump_done  = r_dump_done;

endmodule

`default_nettype wire

// File: tb/tb_regbank_read_port.sv
// +--------------------------------------------------------------------------+
// | tb_regbank_read_port                                                     |
// | Scoreboard bench: read path and dump engine of regbank_read_port.        |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_regbank_read_port;

  logic           clk;
  logic           reset;
  logic [1023:0]  bank_q;
  logic           we;
  logic [4:0]     waddr;
  logic [31:0]    wdata;
  logic           stall;
  logic [4:0]     rs1_addr;
  logic [4:0]     rs2_addr;
  logic [31:0]    rs1_data;
  logic [31:0]    rs2_data;
  logic           dump_start;
  logic           dump_ready;
  logic           dump_valid;
  logic [4:0]     dump_index;
  logic [31:0]    dump_data;
  logic           dump_busy;
  logic           dump_done;

  logic [31:0] bank [32];

  typedef struct { int due; logic [31:0] rs1; logic [31:0] rs2; } rd_exp_t;
  typedef struct { logic [4:0] idx; logic [31:0] data; } beat_t;

  rd_exp_t rd_q[$];
  beat_t   dump_q[$];

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  int done_cnt = 0;
  int last_idx = -1;
  bit hold_flag = 0;
  logic [4:0]  hold_idx;
  logic [31:0] hold_data;
  rd_exp_t e;
  beat_t   b;

  regbank_read_port u_dut (
    .clk        (clk),
    .reset      (reset),
    .bank_q     (bank_q),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .stall      (stall),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_index (dump_index),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    bank_q = '0;
    for (int i = 0; i < 32; i++) bank_q[i*32 +: 32] = bank[i];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: read results by due cycle, dump beats on handshake, hold stability, done.
  always @(negedge clk) begin
    if (!reset) begin
      hold_flag = 0;
    end else begin
      if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
        e = rd_q.pop_front();
        chk("rs1_data", rs1_data, e.rs1);
        chk("rs2_data", rs2_data, e.rs2);
      end
      if (hold_flag && dump_valid) begin
        chk("hold_index", dump_index, hold_idx);
        chk("hold_data", dump_data, hold_data);
      end
      hold_flag = 0;
      if (dump_valid) begin
        if (dump_ready) begin
          if (dump_q.size() == 0) begin
            n_chk++;
            $display("FAIL beat_unexpected: got index %0d expected no beat", dump_index);
          end else begin
            b = dump_q.pop_front();
            chk("beat_index", dump_index, b.idx);
            chk("beat_data", dump_data, b.data);
            last_idx = b.idx;
          end
        end else begin
          hold_flag = 1;
          hold_idx  = dump_index;
          hold_data = dump_data;
        end
      end
      if (dump_done) begin
        done_cnt++;
        chk("done_pending_beats", dump_q.size(), 0);
        chk("done_last_index", last_idx, 31);
      end
    end
  end

  task automatic rd_step(input logic st, input logic [4:0] a1, input logic [4:0] a2,
                         input logic w, input logic [4:0] wa, input logic [31:0] wd,
                         input logic [31:0] e1, input logic [31:0] e2);
    stall = st; rs1_addr = a1; rs2_addr = a2; we = w; waddr = wa; wdata = wd;
    rd_q.push_back('{due: cyc + 1, rs1: e1, rs2: e2});
    @(posedge clk); #1;
  endtask

  task automatic push_all_beats();
    for (int i = 0; i < 32; i++) dump_q.push_back('{idx: 5'(i), data: 32'(i * 3)});
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    int k;
    int hold_cnt;
    reset = 1'b0; we = 0; waddr = 0; wdata = 0; stall = 0;
    rs1_addr = 0; rs2_addr = 0; dump_start = 0; dump_ready = 0;
    for (int i = 0; i < 32; i++) bank[i] = 32'h0;
    tick(); tick();
    chk("reset_rs1", rs1_data, 0);
    chk("reset_rs2", rs2_data, 0);
    chk("reset_dump_flags", {dump_valid, dump_busy, dump_done}, 3'b000);
    chk("reset_dump_index", dump_index, 0);
    chk("reset_dump_data", dump_data, 0);
    reset = 1'b1;
    tick();

    // Plain read, bypass, zero rule, stall
    bank[5] = 32'hDEADBEEF; bank[0] = 32'h1234; bank[7] = 32'h0;
    bank[3] = 32'h11; bank[4] = 32'h22;
    rd_step(0, 5, 0, 0, 0, 0,            32'hDEADBEEF, 32'h0);
    rd_step(0, 7, 7, 1, 7, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5);
    rd_step(0, 0, 5, 1, 0, 32'hFFFFFFFF, 32'h0,        32'hDEADBEEF);
    rd_step(0, 7, 4, 0, 0, 0,            32'h0,        32'h22);
    rd_step(0, 3, 3, 0, 0, 0,            32'h11,       32'h11);
    rd_step(1, 4, 4, 0, 0, 0,            32'h11,       32'h11);
    rd_step(1, 4, 4, 0, 0, 0,            32'h11,       32'h11);
    rd_step(1, 4, 4, 0, 0, 0,            32'h11,       32'h11);
    rd_step(0, 4, 4, 0, 0, 0,            32'h22,       32'h22);
    stall = 0; we = 0;
    tick();

    // Dump 1: ready toggles 1010..., then start coinciding with done
    for (int i = 0; i < 32; i++) bank[i] = 32'(i * 3);
    push_all_beats();
    dump_start = 1; dump_ready = 0;
    tick();
    dump_start = 0;
    k = 0;
    while (dump_busy && k < 300) begin
      dump_ready = (k % 2 == 0);
      tick();
      k++;
    end
    if (k >= 300) begin n_chk++; $display("FAIL dump1_timeout: busy after %0d cycles", k); end
    chk("dump1_done_visible", dump_done, 1);
    dump_start = 1;
    tick();
    dump_start = 0;
    chk("no_restart_busy", dump_busy, 0);
    chk("no_restart_valid", dump_valid, 0);
    chk("dump1_done_count", done_cnt, 1);

    // Dump 2: repeated start mid-dump, bank change while beat 12 held
    push_all_beats();
    dump_start = 1; dump_ready = 1;
    tick();
    dump_start = 0;
    k = 0; hold_cnt = 0;
    while (dump_busy && k < 300) begin
      dump_start = (dump_index == 5'd5);
      if (dump_valid && dump_index == 5'd12 && hold_cnt < 3) begin
        dump_ready = 0; bank[12] = 32'hFFFF0000;
        we = 1; waddr = 12; wdata = 32'h00000BAD;
        hold_cnt++;
      end else begin
        dump_ready = 1; we = 0;
      end
      tick();
      k++;
    end
    if (k >= 300) begin n_chk++; $display("FAIL dump2_timeout: busy after %0d cycles", k); end
    dump_start = 0; we = 0; bank[12] = 32'd36;
    tick(); tick();
    chk("dump2_done_count", done_cnt, 2);
    chk("dump2_hold_cycles", hold_cnt, 3);

    // Dump 3: async reset at beat 10 aborts without done
    push_all_beats();
    dump_start = 1; dump_ready = 1;
    tick();
    dump_start = 0;
    k = 0;
    while (!(dump_valid && dump_index == 5'd10) && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) begin n_chk++; $display("FAIL dump3_timeout: beat 10 not seen in %0d cycles", k); end
    reset = 1'b0;
    #1;
    chk("midreset_rs1", rs1_data, 0);
    chk("midreset_rs2", rs2_data, 0);
    chk("midreset_dump_flags", {dump_valid, dump_busy, dump_done}, 3'b000);
    chk("midreset_dump_index", dump_index, 0);
    chk("midreset_dump_data", dump_data, 0);
    dump_q.delete();
    tick();
    reset = 1'b1;
    tick(); tick(); tick();
    chk("abort_done_count", done_cnt, 2);
    chk("abort_busy", dump_busy, 0);

    rd_step(0, 5, 0, 0, 0, 0, 32'd15, 32'h0);
    tick(); tick();
    chk("read_queue_drained", rd_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
